// File: rtl/mr_keystream_packer.sv
// Massey-Rueppel keystream packer: the inner product of the M and N LFSR states
// gives one bit per clock. Bits are packed LSB-first into words and queued in a 2-entry valid/ready FIFO.
module mr_keystream_packer #(
  parameter int LFSR_W = 7,
  parameter int OUT_W  = 8,
  parameter int WARMUP = 14
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [LFSR_W-1:0] i_lfsr_m,
  input  logic [LFSR_W-1:0] i_lfsr_n,
  input  logic              i_start,
  input  logic              i_stop,
  output logic              o_lfsr_load,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [OUT_W-1:0]  o_data,
  output logic              o_busy,
  output logic              o_overflow
);
  localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int WW = $clog2(WARMUP + 2);

  typedef enum logic [1:0] {IDLE, LOAD, WARM, RUN} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg;
  logic [OUT_W-2:0]     shift_reg;
  logic [WW-1:0]        warm_reg;
  logic                 load_reg;
  logic                 overflow_reg;
  logic [1:0]           count_reg;
  logic                 wr_ptr_reg, rd_ptr_reg;
  logic [1:0][OUT_W-1:0] mem;

  logic             ks, word_done, push_ok, pop, full, drop;
  logic [OUT_W-1:0] word;

  assign ks        = ^(i_lfsr_m & i_lfsr_n);
  assign word_done = (state_reg == RUN) && !i_stop && (cnt_reg == CW'(OUT_W - 1));
  assign word      = {ks, shift_reg};
  assign full      = (count_reg == 2'd2);
  assign pop       = o_valid && i_ready;
  assign push_ok   = word_done && (!full || pop);
  assign drop      = word_done && full && !pop;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (i_start && !i_stop) state_next = LOAD;
      LOAD: begin
        if (i_stop) state_next = IDLE;
        else        state_next = (WARMUP > 0) ? WARM : RUN;
      end
      WARM: begin
        if (i_stop)                      state_next = IDLE;
        else if (warm_reg == WW'(1))     state_next = RUN;
      end
      RUN:  if (i_stop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The load strobe is registered so the LFSRs see a clean, glitch-free pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      load_reg  <= 1'b0;
      warm_reg  <= '0;
      cnt_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      load_reg  <= (state_next == LOAD);
      if (state_reg == LOAD)
        warm_reg <= WW'(WARMUP);
      else if (state_reg == WARM && warm_reg != '0)
        warm_reg <= warm_reg - WW'(1);
      if (i_stop || state_reg != RUN) begin
        cnt_reg   <= '0;
        shift_reg <= '0;
      end else if (word_done) begin
        cnt_reg <= '0;
      end else begin
        shift_reg[cnt_reg] <= ks;
        cnt_reg            <= cnt_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_reg    <= '0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)     rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push_ok} - {1'b0, pop};
      if (state_reg == IDLE && state_next == LOAD)
        overflow_reg <= 1'b0;
      else if (drop)
        overflow_reg <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic [OUT_W-1:0] entry_reg;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
        entry_reg <= '0;
      else if (push_ok && (wr_ptr_reg == 1'(gi)))
        entry_reg <= word;
    end
    assign mem[gi] = entry_reg;
  end

  assign o_valid     = (count_reg != 2'd0);
  assign o_data      = mem[rd_ptr_reg];
  assign o_busy      = (state_reg != IDLE);
  assign o_lfsr_load = load_reg;
  assign o_overflow  = overflow_reg;

endmodule

// File: doc/mr_keystream_packer.md
Name: mr_keystream_packer

Overview:
- Downstream consumer of the Massey-Rueppel LFSR pair.
- Each clock it takes the inner product (AND, then XOR-reduce) of the M-register and N-register states as one keystream bit.
- It packs the bits LSB-first into bytes and buffers them in a 2-entry FIFO behind a valid/ready interface.
- It also sequences the LFSR seed-load pulse and a warm-up discard window.

Parameters:
- LFSR_W, 7, width of both LFSR state inputs.
- OUT_W, 8, bits per output word.
- WARMUP, 14, keystream bits discarded after seed load before packing starts; 0 means no warm-up.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_lfsr_m  input  LFSR_W  current M-register state.
- i_lfsr_n  input  LFSR_W  current N-register state.
- i_start  input  1  start request; honoured only in IDLE.
- i_stop  input  1  abort or stop request; honoured in any non-IDLE state.
- o_lfsr_load  output  1  drives both LFSRs' synchronous seed-load input.
- i_ready  input  1  downstream ready.
- o_valid  output  1  FIFO head valid.
- o_data  output  OUT_W  FIFO head word.
- o_busy  output  1  state is not IDLE.
- o_overflow  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE; bit counter=0; shift register=0; warm-up counter=0; FIFO empty.
  - All outputs 0, including o_data and o_overflow.
- Keystream bit: ks = XOR-reduce(i_lfsr_m & i_lfsr_n). It is combinational from the inputs and sampled at each rising edge.
- FSM states: IDLE, LOAD, WARM, RUN.
  - IDLE: on i_start=1 and i_stop=0, go to LOAD.
  - LOAD: lasts exactly 1 cycle; o_lfsr_load=1 (decoded from state, glitch-free); warm-up counter is loaded with WARMUP. Next state is WARM if WARMUP>0, else RUN. The LFSRs hold their seeds in the first cycle after LOAD.
  - WARM: each cycle discards ks and decrements the counter. When the counter is 1 at an edge, the next state is RUN. Exactly WARMUP bits are discarded.
  - RUN: each cycle shifts ks in as shift[cnt] (LSB-first) and increments cnt. When cnt=OUT_W-1, the completed word {ks, shift[OUT_W-2:0]} is pushed to the FIFO on the same edge and cnt wraps to 0.
- i_stop=1 in LOAD/WARM/RUN: next state IDLE; partial word and cnt cleared; FIFO contents retained and still drainable. i_stop takes priority over i_start. i_start outside IDLE is ignored.
- o_lfsr_load is 1 only in LOAD; o_busy = (state != IDLE).
- FIFO (depth 2):
  - o_valid = not empty; o_data = head, and holds stable while o_valid=1 and i_ready=0.
  - Pop when o_valid & i_ready.
  - Push when full with a simultaneous pop: both occur, FIFO stays full.
  - Push when full without a pop: word dropped, o_overflow set to 1. o_overflow clears only on reset or on entering LOAD.
  - Entering LOAD does not flush the FIFO.
- Throughput: 1 word per OUT_W cycles in RUN. First word is valid OUT_W cycles after entering RUN, visible the cycle after the push edge.
- Reset asserted mid-operation returns to the reset values immediately (asynchronous).

Test Plan:
- Reset, then i_start with WARMUP=0 and bench-driven i_lfsr_m=i_lfsr_n=7'h01 held, i_ready=1 → o_lfsr_load high for exactly 1 cycle; o_valid rises 9 cycles after the start edge (1 LOAD cycle + 8 RUN cycles) with o_data=8'hFF.
- Hold M=N=7'h03 (ks=0); after the first word, alternate N between 7'h01 and 7'h00 starting with 7'h01 in the first bit cycle → second word 8'h55 (confirms LSB-first packing).
- WARMUP=14, ks driven 1 for the first 14 bits then 0 → first word 8'h00 (all 14 warm-up bits discarded); o_busy=1 throughout.
- i_ready=0 in RUN with ks=1 → two words 8'hFF buffered. Third completed word is dropped and o_overflow=1. Then i_ready=1 → exactly two pops of 8'hFF. o_overflow stays 1 until the next i_start.
- FIFO full, with i_ready asserted in exactly the cycle a new word completes → pop and push both occur; o_overflow stays 0.
- i_stop after 5 RUN bits → IDLE next cycle, partial word lost, buffered words still drained. A following i_start with M=N=7'h01 yields 8'hFF (cnt restarted at 0). Asserting i_rst_n=0 mid-RUN → all outputs 0 asynchronously.
